// File: rtl/intr_ctrl.sv
// intr_ctrl: multi-channel interrupt controller.
// Latches peripheral requests (per-channel edge or level mode, per-channel
// enable), picks the lowest-index enabled request, and runs a
// request / acknowledge / end-of-interrupt handshake with the MCU.
// Software sees four 32-bit registers on the IO bus, selected by Address[3:2]:
//   0 PENDING (read, write-1-to-clear)
//   1 MASK    (read/write, 1 = channel enabled)
//   2 MODE    (read/write, 1 = level-sensitive, 0 = rising-edge)
//   3 VECTOR  (read; any write signals end-of-interrupt)
module intr_ctrl #(
    parameter int unsigned         NUM_CH      = 8,
    parameter logic [NUM_CH-1:0]   LEVEL_MASK  = '0,
    parameter logic [31:0]         SPURIOUS_ID = 32'hFFFF_FFFF
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq,
    input  logic              IO_cs,
    input  logic              IO_rd,
    input  logic              IO_wr,
    input  logic [31:0]       Address,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              INTR,
    input  logic              INT_ACK
);

    // Handshake states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Register select values on Address[3:2].
    localparam logic [1:0] SEL_PENDING = 2'd0;
    localparam logic [1:0] SEL_MASK    = 2'd1;
    localparam logic [1:0] SEL_MODE    = 2'd2;
    localparam logic [1:0] SEL_VECTOR  = 2'd3;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] pend_q,  pend_d;
    logic [NUM_CH-1:0] mask_q,  mask_d;
    logic [NUM_CH-1:0] mode_q,  mode_d;
    logic [31:0]       vec_q,   vec_d;
    logic [31:0]       rd_q,    rd_d;
    logic [1:0]        state_q, state_d;
    logic              intr_q,  intr_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_sel;
    logic       eoi_wr;
    logic       pend_wr;

    assign wr_en   = IO_cs & IO_wr;
    // A simultaneous write takes precedence; the read is dropped.
    assign rd_en   = IO_cs & IO_rd & ~IO_wr;
    assign reg_sel = Address[3:2];
    assign eoi_wr  = wr_en && (reg_sel == SEL_VECTOR);
    assign pend_wr = wr_en && (reg_sel == SEL_PENDING);

    // Address bits outside [3:2] and write-data bits above NUM_CH carry no meaning.
    logic unused_addr;
    assign unused_addr = ^{Address[31:4], Address[1:0]};

    generate
        if (NUM_CH < 32) begin : g_unused_wr
            logic unused_wr_hi;
            assign unused_wr_hi = ^wr_data[31:NUM_CH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority selection: lowest-index enabled pending channel wins.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] win_onehot;
    logic [31:0]       win_idx;
    logic              win_found;

    assign eligible   = pend_q & mask_q;
    // Isolating the lowest set bit gives the winner as a one-hot vector.
    assign win_onehot = eligible & (~eligible + 1'b1);
    assign win_found  = |eligible;

    // Encode the winning channel number; scanning downward leaves the lowest index.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 32'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM and vector capture
    // ------------------------------------------------------------------
    logic              ack_take;
    logic [NUM_CH-1:0] ack_clear;

    // Next handshake state, vector and the pending bit consumed by an acknowledge.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        ack_take  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // INTR stays up even if the request vanishes; only the
                // acknowledge decides between a real and a spurious vector.
                if (INT_ACK) begin
                    if (win_found) begin
                        vec_d    = win_idx;
                        ack_take = 1'b1;
                        state_d  = ST_SERVICE;
                    end else begin
                        vec_d    = SPURIOUS_ID;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only edge-mode channels are consumed by the acknowledge; a level
    // channel keeps following its input line.
    assign ack_clear = ack_take ? (win_onehot & ~mode_q) : '0;

    assign intr_d = (state_d == ST_REQ);

    // ------------------------------------------------------------------
    // Request capture and software-visible registers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] edge_next;

    assign rise = irq & ~irq_q;
    assign w1c  = pend_wr ? wr_data[NUM_CH-1:0] : '0;
    // A fresh edge outranks a clear (software or acknowledge) in the same cycle.
    assign edge_next = (pend_q & ~w1c & ~ack_clear) | rise;

    // Pending, enable and mode next values.
    always_comb begin
        pend_d = (mode_q & irq) | (~mode_q & edge_next);
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_en && (reg_sel == SEL_MASK)) begin
            mask_d = wr_data[NUM_CH-1:0];
        end
        if (wr_en && (reg_sel == SEL_MODE)) begin
            mode_d = wr_data[NUM_CH-1:0];
        end
    end

    // Read data mux; rd_data holds its previous value when no read is accepted.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            unique case (reg_sel)
                SEL_PENDING: rd_d = 32'(pend_q);
                SEL_MASK:    rd_d = 32'(mask_q);
                SEL_MODE:    rd_d = 32'(mode_q);
                SEL_VECTOR:  rd_d = vec_q;
                default:     rd_d = '0;
            endcase
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, regardless of statement order.
        if (!reset) begin
            irq_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= LEVEL_MASK;
            vec_q   <= SPURIOUS_ID;
            rd_q    <= '0;
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
        end else begin
            irq_q   <= irq;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            intr_q  <= intr_d;
        end
    end

    assign rd_data = rd_q;
    assign INTR    = intr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Testbench for intr_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural reference model of the controller.
module tb_intr_ctrl;

    localparam int          NUM_CH = 8;
    localparam logic [31:0] SPUR   = 32'hFFFF_FFFF;

    logic              sys_clk = 1'b0;
    logic              reset   = 1'b0;
    logic [NUM_CH-1:0] irq     = '0;
    logic              IO_cs   = 1'b0;
    logic              IO_rd   = 1'b0;
    logic              IO_wr   = 1'b0;
    logic [31:0]       Address = '0;
    logic [31:0]       wr_data = '0;
    logic [31:0]       rd_data;
    logic              INTR;
    logic              INT_ACK = 1'b0;

    int errors = 0;
    int checks = 0;

    intr_ctrl #(
        .NUM_CH      (NUM_CH),
        .LEVEL_MASK  (8'h00),
        .SPURIOUS_ID (SPUR)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .irq     (irq),
        .IO_cs   (IO_cs),
        .IO_rd   (IO_rd),
        .IO_wr   (IO_wr),
        .Address (Address),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .INTR    (INTR),
        .INT_ACK (INT_ACK)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: the handshake as three phases, registers as plain vectors.
    typedef enum {QUIET, RAISED, SERVING} phase_e;
    phase_e            m_phase = QUIET;
    logic [NUM_CH-1:0] m_pend  = '0;
    logic [NUM_CH-1:0] m_mask  = '0;
    logic [NUM_CH-1:0] m_mode  = '0;
    logic [NUM_CH-1:0] m_prev  = '0;
    logic [31:0]       m_vec   = SPUR;
    logic [31:0]       m_rd    = '0;

    function automatic int lowest_set(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic              wr_en;
        logic              rd_en;
        int                sel;
        int                win;
        logic [NUM_CH-1:0] consumed;
        logic [NUM_CH-1:0] next_pend;
        phase_e            next_phase;
        if (!reset) begin
            m_phase = QUIET;
            m_pend  = '0;
            m_mask  = '0;
            m_mode  = '0;
            m_prev  = '0;
            m_vec   = SPUR;
            m_rd    = '0;
            return;
        end
        wr_en      = IO_cs && IO_wr;
        rd_en      = IO_cs && IO_rd && !wr_en;
        sel        = int'(Address[3:2]);
        win        = lowest_set(m_pend & m_mask);
        consumed   = '0;
        next_phase = m_phase;
        if (rd_en) begin
            case (sel)
                0: m_rd = {24'h0, m_pend};
                1: m_rd = {24'h0, m_mask};
                2: m_rd = {24'h0, m_mode};
                default: m_rd = m_vec;
            endcase
        end
        case (m_phase)
            QUIET:   if (win >= 0) next_phase = RAISED;
            RAISED:  if (INT_ACK) begin
                         if (win >= 0) begin
                             m_vec = win;
                             if (!m_mode[win]) consumed[win] = 1'b1;
                             next_phase = SERVING;
                         end else begin
                             m_vec = SPUR;
                             next_phase = QUIET;
                         end
                     end
            default: if (wr_en && sel == 3) next_phase = QUIET;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_mode[i]) begin
                next_pend[i] = irq[i];
            end else begin
                next_pend[i] = (irq[i] && !m_prev[i]) ||
                               (m_pend[i] && !consumed[i] &&
                                !(wr_en && sel == 0 && wr_data[i]));
            end
        end
        if (wr_en && sel == 1) m_mask = wr_data[NUM_CH-1:0];
        if (wr_en && sel == 2) m_mode = wr_data[NUM_CH-1:0];
        m_pend  = next_pend;
        m_prev  = irq;
        m_phase = next_phase;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: update the model, then sample the DUT 1 ns after the edge.
    task automatic step();
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [31:0] d);
        IO_cs   = 1'b1;
        IO_wr   = 1'b1;
        Address = {28'h0, sel, 2'b00};
        wr_data = d;
        step();
        IO_cs   = 1'b0;
        IO_wr   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [31:0] d);
        IO_cs   = 1'b1;
        IO_rd   = 1'b1;
        Address = {28'h0, sel, 2'b00};
        step();
        IO_cs   = 1'b0;
        IO_rd   = 1'b0;
        d       = rd_data;
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        step();
        INT_ACK = 1'b0;
    endtask

    logic [31:0] r;
    int          roll;

    initial begin
        // Reset state
        step();
        step();
        check("reset_intr", {31'b0, INTR}, 32'h0);
        check("reset_rd", rd_data, 32'h0);
        reset = 1'b1;
        read_reg(2'd0, r); check("reset_pending", r, 32'h0);
        read_reg(2'd1, r); check("reset_mask", r, 32'h0);
        read_reg(2'd2, r); check("reset_mode", r, 32'h0);
        read_reg(2'd3, r); check("reset_vector", r, SPUR);

        // Single edge request on channel 0 through the full handshake
        write_reg(2'd1, 32'h01);
        irq = 8'h01;
        step();
        irq = 8'h00;
        check("t1_intr_n1", {31'b0, INTR}, 32'h0);
        read_reg(2'd0, r);
        check("t1_pending_n1", r, 32'h01);
        check("t1_intr_n2", {31'b0, INTR}, 32'h1);
        ack();
        check("t1_intr_after_ack", {31'b0, INTR}, 32'h0);
        read_reg(2'd3, r); check("t1_vector", r, 32'h0);
        read_reg(2'd0, r); check("t1_pending_cleared", r, 32'h0);
        write_reg(2'd3, 32'h0);
        step();
        check("t1_intr_after_eoi", {31'b0, INTR}, 32'h0);

        // Two simultaneous edges: priority order and back-to-back re-raise
        write_reg(2'd1, 32'hFF);
        irq = 8'h24;
        step();
        irq = 8'h00;
        step();
        check("t2_intr", {31'b0, INTR}, 32'h1);
        ack();
        read_reg(2'd3, r); check("t2_vector_first", r, 32'h2);
        read_reg(2'd0, r); check("t2_pending_left", r, 32'h20);
        write_reg(2'd3, 32'h0);
        check("t2_intr_at_eoi", {31'b0, INTR}, 32'h0);
        step();
        check("t2_intr_reraise", {31'b0, INTR}, 32'h1);
        ack();
        read_reg(2'd3, r); check("t2_vector_second", r, 32'h5);
        write_reg(2'd3, 32'h0);

        // Level channel 3: stays pending while held, held INTR goes spurious
        write_reg(2'd2, 32'h08);
        write_reg(2'd1, 32'h08);
        irq = 8'h08;
        step();
        step();
        check("t3_intr", {31'b0, INTR}, 32'h1);
        ack();
        read_reg(2'd3, r); check("t3_vector", r, 32'h3);
        write_reg(2'd3, 32'h0);
        irq = 8'h00;
        step();
        check("t3_intr_reraise", {31'b0, INTR}, 32'h1);
        read_reg(2'd0, r); check("t3_pending_dropped", r, 32'h0);
        check("t3_intr_held", {31'b0, INTR}, 32'h1);
        ack();
        check("t3_intr_spurious", {31'b0, INTR}, 32'h0);
        read_reg(2'd3, r); check("t3_vector_spurious", r, SPUR);
        write_reg(2'd2, 32'h00);

        // Mask removed while requesting: acknowledge returns the spurious id
        write_reg(2'd1, 32'h02);
        irq = 8'h02;
        step();
        irq = 8'h00;
        step();
        write_reg(2'd1, 32'h00);
        check("t4_intr_held", {31'b0, INTR}, 32'h1);
        ack();
        check("t4_intr_after_ack", {31'b0, INTR}, 32'h0);
        read_reg(2'd3, r); check("t4_vector", r, SPUR);
        step();
        check("t4_stays_idle", {31'b0, INTR}, 32'h0);

        // Edge set beats write-1-to-clear in the same cycle
        write_reg(2'd0, 32'hFF);
        read_reg(2'd0, r); check("t5_pending_clean", r, 32'h0);
        irq = 8'h10;
        write_reg(2'd0, 32'h10);
        read_reg(2'd0, r); check("t5_set_wins", r, 32'h10);
        write_reg(2'd0, 32'h10);
        read_reg(2'd0, r); check("t5_w1c_alone", r, 32'h0);
        irq = 8'h00;

        // Reset in the middle of service
        write_reg(2'd1, 32'h01);
        irq = 8'h01;
        step();
        irq = 8'h00;
        step();
        ack();
        irq = 8'h30;
        step();
        irq = 8'h00;
        read_reg(2'd0, r); check("t6_pending", r, 32'h31 & 32'h30);
        write_reg(2'd1, 32'hFF);
        read_reg(2'd3, r); check("t6_vector_in_service", r, 32'h0);
        check("t6_no_intr_in_service", {31'b0, INTR}, 32'h0);
        ack();
        read_reg(2'd3, r); check("t6_ack_ignored", r, 32'h0);
        reset = 1'b0;
        step();
        check("t6_intr_reset", {31'b0, INTR}, 32'h0);
        check("t6_rd_reset", rd_data, 32'h0);
        reset = 1'b1;
        read_reg(2'd0, r); check("t6_pending_reset", r, 32'h0);
        read_reg(2'd1, r); check("t6_mask_reset", r, 32'h0);
        read_reg(2'd3, r); check("t6_vector_reset", r, SPUR);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) irq = NUM_CH'($urandom);
            INT_ACK = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 299) != 0);
            roll    = int'($urandom_range(0, 9));
            IO_cs   = (roll < 5) || ($urandom_range(0, 7) == 0);
            IO_rd   = (roll < 2) || (roll == 3);
            IO_wr   = (roll == 2) || (roll == 3) || (roll == 4 && $urandom_range(0, 1) == 1);
            Address = $urandom;
            wr_data = $urandom;
            step();
            check("rand_intr", {31'b0, INTR}, {31'b0, m_phase == RAISED});
            check("rand_rd_data", rd_data, m_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
